ysyx_22041211_lsu: RTL and testbench

Parametrised, multi-cycle load/store unit that replaces the single-cycle combinational memory/write-back path. It sits between the execute stage (upstream valid/ready) and the register-file write port (downstream valid/ready). It drives a request/response memory bus with byte strobes and handles sub-word loads with correct sign/zero extension and byte-lane alignment. Misaligned accesses are flagged instead of being issued.

---
 rtl/ysyx_22041211_lsu.sv | 149 ++++++++++++++
 tb/tb_ysyx_22041211_lsu.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_lsu.sv
// Multi-cycle load/store unit between execute and register write-back.
// Drives a req/resp memory bus with byte strobes; misaligned accesses are flagged, never issued.
module ysyx_22041211_lsu #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  wd_i,
  input  logic [4:0]            wreg_i,
  input  logic [DATA_LEN-1:0]   alu_result_i,
  input  logic [DATA_LEN-1:0]   mem_wdata_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            store_type_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wd_o,
  output logic [4:0]            wreg_o,
  output logic [DATA_LEN-1:0]   wdata_o,
  output logic                  misalign_o,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_LEN-1:0]   mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_LEN-1:0]   mem_req_wdata,
  output logic [DATA_LEN/8-1:0] mem_req_wmask,
  input  logic                  mem_resp_valid,
  input  logic [DATA_LEN-1:0]   mem_resp_rdata
);

  localparam int STRB = DATA_LEN / 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0] ld_q;
  logic [1:0] st_q;
  logic [1:0] off_q;

  logic                accept;
  logic                is_load;
  logic                is_store;
  logic                is_half;
  logic                is_word;
  logic                misalign;
  logic                mem_op;
  logic [STRB-1:0]     base_mask;
  logic [DATA_LEN-1:0] resp_shift;
  logic [DATA_LEN-1:0] load_ext;

  assign accept = in_valid & in_ready;

  // Load wins when both a load and a store type are presented.
  always_comb begin
    is_load   = (load_type_i >= 3'd1) && (load_type_i <= 3'd5);
    is_store  = !is_load && (store_type_i != 2'd0);
    is_half   = (load_type_i == 3'd3) || (load_type_i == 3'd4) ||
                (is_store && store_type_i == 2'd2);
    is_word   = (load_type_i == 3'd5) || (is_store && store_type_i == 2'd3);
    misalign  = (is_half && alu_result_i[0]) || (is_word && (alu_result_i[1:0] != 2'b00));
    mem_op    = is_load || is_store;
    base_mask = '0;
    case (store_type_i)
      2'd1:    base_mask = STRB'(4'b0001);
      2'd2:    base_mask = STRB'(4'b0011);
      2'd3:    base_mask = STRB'(4'b1111);
      default: base_mask = '0;
    endcase
  end

  always_comb begin
    resp_shift = mem_resp_rdata >> {off_q, 3'b000};
    load_ext   = resp_shift;
    case (ld_q)
      3'd1:    load_ext = {{(DATA_LEN-8){resp_shift[7]}}, resp_shift[7:0]};
      3'd2:    load_ext = {{(DATA_LEN-8){1'b0}}, resp_shift[7:0]};
      3'd3:    load_ext = {{(DATA_LEN-16){resp_shift[15]}}, resp_shift[15:0]};
      3'd4:    load_ext = {{(DATA_LEN-16){1'b0}}, resp_shift[15:0]};
      default: load_ext = resp_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)         state_nxt = (mem_op && !misalign) ? REQ : DONE;
      REQ:  if (mem_req_ready)  state_nxt = WAIT;
      WAIT: if (mem_resp_valid) state_nxt = DONE;
      DONE: if (out_ready)      state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready      = (state == IDLE);
    mem_req_valid = (state == REQ);
    out_valid     = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q          <= '0;
      st_q          <= '0;
      off_q         <= '0;
      wd_o          <= 1'b0;
      wreg_o        <= '0;
      wdata_o       <= '0;
      misalign_o    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
    end else begin
      if (accept) begin
        ld_q       <= is_load ? load_type_i : 3'd0;
        st_q       <= is_store ? store_type_i : 2'd0;
        off_q      <= alu_result_i[1:0];
        wreg_o     <= wreg_i;
        wd_o       <= wd_i & ~misalign;
        misalign_o <= misalign;
        wdata_o    <= mem_op ? '0 : alu_result_i;
        // Bus fields only change for accesses that are actually issued.
        if (mem_op && !misalign) begin
          mem_req_addr  <= {alu_result_i[ADDR_LEN-1:2], 2'b00};
          mem_req_wen   <= is_store;
          mem_req_wdata <= is_store ? (mem_wdata_i << {alu_result_i[1:0], 3'b000}) : '0;
          mem_req_wmask <= is_store ? (base_mask << alu_result_i[1:0]) : '0;
        end
      end
      if (state == WAIT && mem_resp_valid) begin
        if (st_q != 2'd0) begin
          wd_o    <= 1'b0;
          wdata_o <= '0;
        end else begin
          wdata_o <= load_ext;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Scoreboard bench for the LSU: expected write-back results are queued at issue
// and compared when out_valid appears; bus requests are checked as they are presented.
module tb_ysyx_22041211_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] alu_result_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic        out_valid;
  logic        out_ready;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;
  logic        misalign_o;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int checks   = 0;
  int failures = 0;

  logic [38:0] exp_q[$];

  ysyx_22041211_lsu #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i),
    .mem_wdata_i(mem_wdata_i), .load_type_i(load_type_i), .store_type_i(store_type_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [38:0] res(input logic m, input logic w, input logic [4:0] r,
                                      input logic [31:0] d);
    return {m, w, r, d};
  endfunction

  // One full transaction; inputs change and outputs are sampled on falling edges.
  task automatic run_op(input string name, input logic w, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] l, input logic [1:0] s,
                        input logic req, input logic [31:0] raddr, input logic rwen,
                        input logic [3:0] rmask, input logic [31:0] rwdata,
                        input int stall, input logic [31:0] rdata, input logic [38:0] exp,
                        input int hold);
    int n;
    logic [38:0] e;
    @(negedge clk);
    check({name, ":in_ready"}, in_ready, 1);
    in_valid = 1'b1; wd_i = w; wreg_i = r; alu_result_i = a; mem_wdata_i = d;
    load_type_i = l; store_type_i = s;
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    if (req) begin
      for (int i = 0; i <= stall; i++) begin
        check({name, ":req"}, {mem_req_valid, mem_req_wen, mem_req_wmask, mem_req_addr},
              {1'b1, rwen, rmask, raddr});
        check({name, ":req_wdata"}, mem_req_wdata, rwdata);
        if (i < stall) @(negedge clk);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      check({name, ":req_drop"}, {mem_req_valid, out_valid}, 2'b00);
      mem_resp_valid = 1'b1;
      mem_resp_rdata = rdata;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      mem_resp_rdata = 32'hDEAD_0000;
    end else begin
      check({name, ":no_req"}, mem_req_valid, 0);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req) check({name, ":latency"}, n, 0);
    if (!out_valid) begin
      check({name, ":out_timeout"}, out_valid, 1);
    end else begin
      e = exp_q.pop_front();
      check({name, ":result"}, {misalign_o, wd_o, wreg_o, wdata_o}, e);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({name, ":hold"}, {out_valid, in_ready, misalign_o, wd_o, wreg_o, wdata_o},
              {1'b1, 1'b0, e});
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, ":drain"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; wd_i = 1'b0; wreg_i = '0; alu_result_i = '0;
    mem_wdata_i = '0; load_type_i = '0; store_type_i = '0; out_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {in_ready, out_valid, mem_req_valid, misalign_o, wd_o}, 5'b10000);
    check("reset_data", {wreg_o, wdata_o, mem_req_addr, mem_req_wmask}, '0);
    rst = 1'b0;

    run_op("nomem", 1, 5, 32'h0000_1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
           res(0, 1, 5, 32'h0000_1234), 0);
    run_op("lb", 1, 7, 32'h8000_0003, 0, 1, 0, 1, 32'h8000_0000, 0, 4'b0000, 0, 0,
           32'h80FF_0000, res(0, 1, 7, 32'hFFFF_FF80), 0);
    run_op("lbu", 1, 8, 32'h8000_0003, 0, 2, 0, 1, 32'h8000_0000, 0, 4'b0000, 0, 1,
           32'h80FF_0000, res(0, 1, 8, 32'h0000_0080), 0);
    run_op("lh", 1, 9, 32'h8000_0002, 0, 3, 0, 1, 32'h8000_0000, 0, 4'b0000, 0, 0,
           32'h8001_7FFF, res(0, 1, 9, 32'hFFFF_8001), 0);
    run_op("lhu", 1, 10, 32'h8000_0002, 0, 4, 0, 1, 32'h8000_0000, 0, 4'b0000, 0, 0,
           32'h8001_7FFF, res(0, 1, 10, 32'h0000_8001), 0);
    run_op("sb", 1, 11, 32'h8000_0001, 32'h0000_00AB, 0, 1, 1, 32'h8000_0000, 1, 4'b0010,
           32'h0000_AB00, 3, 0, res(0, 0, 11, 0), 0);
    run_op("lw_mis", 1, 12, 32'h8000_0002, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0,
           res(1, 0, 12, 0), 0);
    run_op("sh_mis", 1, 13, 32'h8000_0001, 32'h1234, 0, 2, 0, 0, 0, 0, 0, 0, 0,
           res(1, 0, 13, 0), 0);
    run_op("lw_hold", 1, 14, 32'h8000_0004, 0, 5, 0, 1, 32'h8000_0004, 0, 4'b0000, 0, 0,
           32'hDEAD_BEEF, res(0, 1, 14, 32'hDEAD_BEEF), 5);
    run_op("sw", 1, 15, 32'h8000_0008, 32'hCAFE_F00D, 0, 3, 1, 32'h8000_0008, 1, 4'b1111,
           32'hCAFE_F00D, 1, 0, res(0, 0, 15, 0), 0);
    run_op("sh", 0, 16, 32'h8000_0002, 32'h0000_1234, 0, 2, 1, 32'h8000_0000, 1, 4'b1100,
           32'h1234_0000, 0, 0, res(0, 0, 16, 0), 0);
    run_op("lt6", 1, 17, 32'h0000_00FF, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0,
           res(0, 1, 17, 32'h0000_00FF), 0);
    run_op("ld_wins", 1, 18, 32'h8000_0001, 32'h5555_5555, 1, 3, 1, 32'h8000_0000, 0,
           4'b0000, 0, 0, 32'h0000_7F00, res(0, 1, 18, 32'h0000_007F), 0);

    // Reset while waiting for a response; the late response must be ignored.
    @(negedge clk);
    in_valid = 1'b1; wd_i = 1'b1; wreg_i = 5'd3; alu_result_i = 32'h8000_0010;
    load_type_i = 3'd5; store_type_i = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    check("rst_wait_entry", {mem_req_valid, out_valid, in_ready}, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    repeat (2) begin
      check("rst_wait_ctrl", {out_valid, in_ready, mem_req_valid, wd_o}, 4'b0100);
      check("rst_wait_data", {wdata_o, mem_req_addr}, '0);
      @(negedge clk);
    end

    run_op("after_rst", 1, 19, 32'h0000_ABCD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
           res(0, 1, 19, 32'h0000_ABCD), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
